// File: rtl/circ_queue16_if.sv
// Producer/consumer bundle for circ_queue16: request, data and status signals.
interface circ_queue16_if;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 5;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             udf;

    modport master (
        output push, pop, data_in,
        input  data_out, full, empty, count, ovf, udf
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, full, empty, count, ovf, udf
    );
endinterface

// File: rtl/circ_queue16.sv
// 16 x 16-bit circular FIFO with head/tail pointers, an occupancy counter,
// first-word-fall-through read and registered overflow/underflow pulses.
module circ_queue16 (
    input  logic           clk,
    input  logic           reset,
    circ_queue16_if.slave  q
);
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;
    localparam int unsigned CNT_W = 5;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic full_c;
    logic empty_c;
    logic push_ok_c;
    logic pop_ok_c;

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    // A push into a full queue is fine when a pop frees the head slot on the same edge.
    assign push_ok_c = q.push & (~full_c | q.pop);
    assign pop_ok_c  = q.pop & ~empty_c;

    // Next-state for storage, pointers, occupancy and error pulses.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = q.push & full_c & ~q.pop;
        udf_d   = q.pop & empty_c;

        if (push_ok_c) begin
            mem_d[tail_q] = q.data_in;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Head word falls through; an empty queue reads as zero.
    assign q.data_out = empty_c ? '0 : mem_q[head_q];
    assign q.full     = full_c;
    assign q.empty    = empty_c;
    assign q.count    = count_q;
    assign q.ovf      = ovf_q;
    assign q.udf      = udf_q;
endmodule

// File: tb/tb_circ_queue16.sv
// Directed bench for circ_queue16: fill/drain, overflow/underflow pulses,
// pointer wrap, simultaneous push+pop at the boundaries, and mid-run reset.
module tb_circ_queue16;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    circ_queue16_if qi ();

    circ_queue16 dut (
        .clk   (clk),
        .reset (reset),
        .q     (qi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs, advance one edge, settle for sampling.
    task automatic cyc(input logic ps, input logic pp, input logic [15:0] d);
        qi.push    = ps;
        qi.pop     = pp;
        qi.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_empty(input string tag);
        chk({tag, ".empty"}, 32'(qi.empty), 32'd1);
        chk({tag, ".full"},  32'(qi.full),  32'd0);
        chk({tag, ".count"}, 32'(qi.count), 32'd0);
        chk({tag, ".dout"},  32'(qi.data_out), 32'h0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        qi.push    = 1'b0;
        qi.pop     = 1'b0;
        qi.data_in = '0;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        reset = 1'b0;

        // Reset state after three idle cycles
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
        chk_idle_empty("rst");
        chk("rst.ovf", 32'(qi.ovf), 32'd0);
        chk("rst.udf", 32'(qi.udf), 32'd0);

        // Fill with 0001..0010
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 16'(i + 1));
            chk("fill.count", 32'(qi.count), 32'(i + 1));
            chk("fill.dout",  32'(qi.data_out), 32'h0001);
            chk("fill.full",  32'(qi.full), (i == 15) ? 32'd1 : 32'd0);
        end

        // Overflow pulse on a lone push into a full queue
        cyc(1'b1, 1'b0, 16'hBEEF);
        chk("ovf.pulse", 32'(qi.ovf),   32'd1);
        chk("ovf.count", 32'(qi.count), 32'd16);
        cyc(1'b0, 1'b0, 16'h0);
        chk("ovf.clear", 32'(qi.ovf),   32'd0);
        chk("ovf.dout",  32'(qi.data_out), 32'h0001);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            chk("drain.dout", 32'(qi.data_out), 32'(i + 1));
            cyc(1'b0, 1'b1, 16'h0);
            chk("drain.count", 32'(qi.count), 32'(15 - i));
        end
        chk_idle_empty("drained");

        // Underflow pulse
        cyc(1'b0, 1'b1, 16'h0);
        chk("udf.pulse", 32'(qi.udf),   32'd1);
        chk("udf.count", 32'(qi.count), 32'd0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("udf.clear", 32'(qi.udf),   32'd0);

        // Wrap-around: push 10 / pop 10 / push 12 / pop 12
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'(16'h0100 + i));
        chk("wrap.cnt10", 32'(qi.count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap.a", 32'(qi.data_out), 32'(16'h0100 + i));
            cyc(1'b0, 1'b1, 16'h0);
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 16'(16'h0200 + i));
        chk("wrap.cnt12", 32'(qi.count), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("wrap.b", 32'(qi.data_out), 32'(16'h0200 + i));
            cyc(1'b0, 1'b1, 16'h0);
        end
        chk_idle_empty("wrap");
        chk("wrap.head", 32'(dut.head_q), 32'd6);
        chk("wrap.tail", 32'(dut.tail_q), 32'd6);

        // Full + simultaneous push/pop
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16'(i + 1));
        chk("fpp.full", 32'(qi.full), 32'd1);
        chk("fpp.pre",  32'(qi.data_out), 32'h0001);
        cyc(1'b1, 1'b1, 16'hAAAA);
        chk("fpp.count", 32'(qi.count), 32'd16);
        chk("fpp.ovf",   32'(qi.ovf),   32'd0);
        chk("fpp.udf",   32'(qi.udf),   32'd0);
        for (int i = 2; i <= 16; i++) begin
            chk("fpp.drain", 32'(qi.data_out), 32'(i));
            cyc(1'b0, 1'b1, 16'h0);
        end
        chk("fpp.last", 32'(qi.data_out), 32'hAAAA);
        cyc(1'b0, 1'b1, 16'h0);
        chk_idle_empty("fpp");

        // Empty + simultaneous push/pop: pop rejected, push lands
        cyc(1'b1, 1'b1, 16'h5555);
        chk("epp.udf",   32'(qi.udf),   32'd1);
        chk("epp.count", 32'(qi.count), 32'd1);
        chk("epp.dout",  32'(qi.data_out), 32'h5555);
        cyc(1'b0, 1'b1, 16'h0);
        chk("epp.udf2",  32'(qi.udf),   32'd0);
        chk("epp.count2", 32'(qi.count), 32'd0);

        // Reset mid-operation with push/pop asserted on the reset edge
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'(16'h0300 + i));
        chk("mrst.pre", 32'(qi.count), 32'd5);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 16'hFFFF);
        reset = 1'b0;
        qi.push = 1'b0;
        qi.pop  = 1'b0;
        chk_idle_empty("mrst");
        chk("mrst.ovf", 32'(qi.ovf), 32'd0);
        chk("mrst.udf", 32'(qi.udf), 32'd0);
        cyc(1'b1, 1'b0, 16'h1234);
        chk("mrst.dout",  32'(qi.data_out), 32'h1234);
        chk("mrst.count", 32'(qi.count), 32'd1);
        cyc(1'b0, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/circ_queue16.md
Name: circ_queue16

Overview:
- 16-entry × 16-bit circular FIFO: head/tail pointers plus an occupancy counter.
- Storage is built from the team's flop primitives, one reset-clearing load-enable flop per bit. Write-steering uses demux16; head-entry read uses mux16; pointer/count arithmetic uses the ha/fa/addsub cells.
- Sits directly downstream of the gate/flop library as the block that consumes it. Feeds the system-level producer/consumer interface.

Parameters:
- WIDTH, 16, data word width; only 16 supported.
- DEPTH, 16, number of entries; fixed, so pointers are 4 bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  enqueue request, sampled at posedge.
- pop  input  1  dequeue request, sampled at posedge.
- data_in  input  16  word to enqueue.
- data_out  output  16  word at head, first-word-fall-through; 0 when empty.
- full  output  1  count == 16.
- empty  output  1  count == 0.
- count  output  5  occupancy, 0..16.
- ovf  output  1  registered 1-cycle pulse: push rejected.
- udf  output  1  registered 1-cycle pulse: pop rejected.

Behaviour:
- Clocking/reset: single clock domain, clk. Reset is synchronous and active-high on port reset: sampled only at posedge clk and overrides push/pop.
- Reset values:
  - head = 0, tail = 0, count = 0.
  - All 16 storage words = 0.
  - ovf = 0, udf = 0.
  - Hence empty = 1, full = 0, data_out = 0.
- State: head[3:0] (read index), tail[3:0] (write index), count[4:0].
  - full and empty are combinational decodes of count.
  - No separate FSM; the three states are EMPTY (count=0), PARTIAL (1..15) and FULL (16), derived from count.
- Accept rules, evaluated on pre-edge state:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
- Push_ok: mem[tail] <= data_in; tail <= tail+1 mod 16 (15 wraps to 0).
- Pop_ok: head <= head+1 mod 16. The word is not cleared.
- Count update:
  - push_ok & !pop_ok: count+1.
  - pop_ok & !push_ok: count-1.
  - Both: unchanged.
- Simultaneous push+pop:
  - PARTIAL: both accepted, count unchanged.
  - FULL: both accepted; the write goes to tail (== head), and the old head is the word popped this cycle. No ovf.
  - EMPTY: push accepted, pop rejected, udf pulses, count becomes 1. No bypass: data_out stays 0 that cycle and shows data_in from the next cycle.
- Errors:
  - ovf <= push & full & !pop.
  - udf <= pop & empty.
  - Rejected requests change no other state. Pulses appear the cycle after the offending edge and are held for one cycle only.
- Read path: data_out = mem[head] when !empty, else 16'h0000. Combinational from registered state, so it is valid in the same cycle count becomes nonzero.
- Latency: push to visible-at-head (when empty before) is 1 cycle. Pop to next word at data_out is 1 cycle.
- Reset mid-operation: any contents are discarded; the next cycle is identical to post-reset state regardless of push/pop on the reset edge.
- Invariant: (tail - head) mod 16 == count mod 16. Whenever count is 0 or 16, head == tail.
- No X propagation: all storage is reset, so data_out is defined from the first post-reset cycle.

Test Plan:
- Reset, idle 3 cycles → empty=1, full=0, count=0, data_out=0000, ovf=udf=0.
- Push 16'h0001..16'h0010 on 16 consecutive cycles → count steps 1..16, full=1 after 16th edge, data_out=0001 throughout.
- From full, push 16'hBEEF alone → ovf=1 for exactly one cycle, count=16, contents unchanged. Then pop 16 times → data_out sequence 0001..0010, empty=1, one further pop → udf=1 pulse.
- Wrap-around: push 10, pop 10, push 12 (tail wraps 10→15→0..5), pop 12 → FIFO order preserved, head=tail=6, count=0.
- Full + simultaneous push(16'hAAAA)+pop → popped 0001, count stays 16, no ovf; drain and confirm AAAA is last out. Empty + push(16'h5555)+pop → udf pulse, count=1, next-cycle data_out=5555.
- Push 5 words, assert reset with push=pop=1 on the same edge → next cycle count=0, empty=1, data_out=0000. Subsequent push 16'h1234 → data_out=1234.
